// File: rtl/ysyx_22041461_pkg.sv
// Shared fetch-side types and constants for the ysyx_22041461 core.
// Control unit and execute import these alongside the IFU.
package ysyx_22041461_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h8000_0000;
  localparam logic [ILEN-1:0] INST_NOP         = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_RESET,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_HALT
  } ifu_state_t;

endpackage

// File: rtl/ysyx_22041461_pc_reg.sv
// Program counter, pending redirect target, drop flag and next-PC selection.
// Flags a misaligned target at the point it would be committed to the PC.
module ysyx_22041461_pc_reg
  import ysyx_22041461_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_reset,
  input  logic            step,
  input  logic            arm,
  input  logic            commit,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] snpc,
  output logic            drop,
  output logic            commit_misalign
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pending_q;
  logic            drop_q;
  logic [XLEN-1:0] commit_pc;
  logic [XLEN-1:0] pc_next;

  // A redirect arriving in the commit cycle is newer than anything pending.
  assign commit_pc       = redirect_valid ? redirect_pc : pending_q;
  assign commit_misalign = |commit_pc[1:0];

  always_comb begin
    pc_next = pc_q;
    if (load_reset) begin
      pc_next = RESET_PC;
    end else if (commit) begin
      pc_next = commit_pc;
    end else if (step) begin
      pc_next = pc_q + 64'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      pending_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      pc_q <= pc_next;
      if (arm) begin
        pending_q <= redirect_pc;
        drop_q    <= 1'b1;
      end else if (commit) begin
        drop_q <= 1'b0;
      end
    end
  end

  assign pc   = pc_q;
  assign snpc = pc_q + 64'd4;
  assign drop = drop_q;

endmodule

// File: rtl/ysyx_22041461_ifu.sv
// Instruction fetch unit: one doubleword read per instruction, word select by pc[2],
// valid/ready hand-off to decode, and redirect handling from execute.
module ysyx_22041461_ifu
  import ysyx_22041461_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] snpc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_misalign
);

  // state | meaning
  // RESET | out of reset, PC loaded with RESET_PC
  // REQ   | request for {pc[63:3],3'b0} held until accepted
  // WAIT  | request accepted, waiting for read data
  // OUT   | instruction presented to decode
  // HALT  | misaligned target committed, fetch stopped until reset

  ifu_state_t      state;
  logic [ILEN-1:0] inst_r;
  logic            misalign_r;

  logic            drop;
  logic            commit_misalign;
  logic            rsp_take;
  logic            discard;
  logic            arm;
  logic            commit;
  logic            step;
  logic            load_reset;

  assign rsp_take   = (state == S_WAIT) && mem_rsp_valid;
  assign discard    = rsp_take && (drop || redirect_valid);
  assign arm        = redirect_valid &&
                      ((state == S_REQ) || ((state == S_WAIT) && !mem_rsp_valid));
  assign commit     = discard || ((state == S_OUT) && redirect_valid);
  assign step       = (state == S_OUT) && inst_ready && !redirect_valid;
  assign load_reset = (state == S_RESET);

  ysyx_22041461_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk             (clk),
    .rst_n           (rst_n),
    .load_reset      (load_reset),
    .step            (step),
    .arm             (arm),
    .commit          (commit),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .pc              (pc),
    .snpc            (snpc),
    .drop            (drop),
    .commit_misalign (commit_misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RESET;
      inst_r     <= INST_NOP;
      misalign_r <= 1'b0;
    end else begin
      if (rsp_take) begin
        inst_r <= pc[2] ? mem_rsp_data[63:32] : mem_rsp_data[31:0];
      end
      if (commit && commit_misalign) begin
        misalign_r <= 1'b1;
      end
      case (state)
        S_RESET: state <= S_REQ;
        S_REQ: begin
          if (mem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            if (discard) state <= commit_misalign ? S_HALT : S_REQ;
            else         state <= S_OUT;
          end
        end
        S_OUT: begin
          // Redirect wins over the pc+4 step even when decode takes the instruction.
          if (redirect_valid)  state <= commit_misalign ? S_HALT : S_REQ;
          else if (inst_ready) state <= S_REQ;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_RESET;
      endcase
    end
  end

  assign mem_req_valid  = (state == S_REQ);
  assign mem_req_addr   = {pc[XLEN-1:3], 3'b000};
  assign inst_valid     = (state == S_OUT);
  assign inst           = inst_r;
  assign fetch_misalign = misalign_r;

endmodule
